// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: buffers signed operand pairs in a 2-deep FIFO and runs each one through an
// external multiplier, returning products (or timeout aborts) in acceptance order.
module mult_job_sequencer #(
    parameter int N       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_start,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic [2*N-1:0] mul_result,
    input  logic           mul_done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_result,
    output logic           out_err,
    output logic           busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t                  state_q, state_d;
    logic [1:0][2*N-1:0]     mem_q, mem_d;
    logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic [N-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                    arm_q, arm_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [2*N-1:0]          out_result_q, out_result_d;
    logic                    push, pop, out_fire;
    assign in_ready   = count_q != 2'd2;
    assign mul_start  = state_q == ISSUE;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign busy       = state_q != IDLE;
    always_comb begin
        push     = in_valid && in_ready;
        pop      = state_q == ISSUE;
        out_fire = out_valid_q && out_ready;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {in_a, in_b};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
    // Operands are loaded on the way into ISSUE so they are already valid while mul_start is high.
    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        arm_d        = arm_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q && !out_fire;
        case (state_q)
            IDLE: if (count_q != 2'd0 && (!out_valid_q || out_fire)) begin
                state_d            = ISSUE;
                {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
            end
            ISSUE: begin
                state_d = WAIT;
                arm_d   = 1'b0;
                cnt_d   = '0;
            end
            WAIT: begin
                arm_d = arm_q || !mul_done;
                cnt_d = cnt_q + CW'(1);
                if (arm_q && mul_done) begin
                    state_d      = HOLD;
                    out_result_d = mul_result;
                    out_err_d    = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = HOLD;
                    out_result_d = '0;
                    out_err_d    = 1'b1;
                end
            end
            HOLD: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            arm_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            arm_q        <= arm_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
        end
    end
endmodule

// File: doc/mult_job_sequencer.md
MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

Interface
REQ-001 Parameter N, default 2: operand width in bits; results are 2N bits.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before a job is aborted.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  operand buffer can accept
in_a  in  N  signed multiplicand
in_b  in  N  signed multiplier
mul_start  out  1  one-cycle start pulse to serial_parallel_multiplier
mul_a  out  N  operand a to multiplier
mul_b  out  N  operand b to multiplier
mul_result  in  2N  signed product from multiplier
mul_done  in  1  multiplier completion level
out_valid  out  1  result slot occupied
out_ready  in  1  consumer accepts result
out_result  out  2N  signed product
out_err  out  1  result was produced by timeout abort
busy  out  1  high in any state other than IDLE

Function
REQ-004 Input buffer SHALL be a 2-entry FIFO; accept occurs when in_valid and in_ready are both high on a rising edge; in_ready = not full.
REQ-005 Simultaneous accept and pop on a full FIFO SHALL NOT be allowed, because in_ready is low when the FIFO is full; on a 1-entry FIFO, push and pop in the same cycle SHALL keep the count at 1.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-007 IDLE -> ISSUE when the FIFO is non-empty and the output slot is free, or out_valid and out_ready are both high in that cycle; otherwise stay in IDLE.
REQ-008 ISSUE SHALL last exactly 1 cycle: pop the FIFO head into mul_a/mul_b, drive mul_start=1, then go to WAIT.
REQ-009 mul_a and mul_b SHALL remain stable from ISSUE until the next ISSUE; mul_start=0 in all states except ISSUE.
REQ-010 WAIT: an internal arm flag SHALL clear on entry and set on the first WAIT cycle with mul_done=0; a high mul_done before arming SHALL be ignored as stale.
REQ-011 WAIT -> HOLD when armed and mul_done=1: capture mul_result into out_result, set out_err=0.
REQ-012 WAIT cycle counter: when it reaches TIMEOUT without capture -> HOLD with out_result=0 and out_err=1.
REQ-013 HOLD SHALL last 1 cycle: set out_valid=1, then go to IDLE.
REQ-014 out_valid, out_result and out_err SHALL hold until the cycle out_valid and out_ready are both high, after which out_valid=0 unless a new HOLD sets it in that same cycle.
REQ-015 Results SHALL be delivered in operand-acceptance order; no job is dropped or duplicated.
REQ-016 Minimum job latency from accept to out_valid SHALL be 3 cycles plus the multiplier latency.
REQ-017 The block SHALL perform no arithmetic on operands; out_result SHALL be bit-exact to mul_result.

Reset
REQ-018 Asserting rst at any time, including mid-WAIT, SHALL immediately clear: FIFO empty, state=IDLE, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_result=0, out_err=0, busy=0, counters 0, arm=0.
REQ-019 in_ready SHALL be 1 while rst is high and after reset (FIFO empty).
REQ-020 After rst deasserts, the first mul_start SHALL occur no earlier than 2 cycles after the first accept.

Verification (N=2, real serial_parallel_multiplier unless noted)
REQ-021 Accept (-2,-2), out_ready=1 -> exactly one mul_start pulse; out_result=4 (0100), out_err=0, one out_valid cycle.
REQ-022 All 16 pairs from -2..1 streamed back-to-back with in_valid held high -> 16 results in order, each equal to a*b (e.g. (-2,1) -> 1110, (1,1) -> 0001), with no gaps or duplicates.
REQ-023 out_ready=0 for 20 cycles with 3 jobs offered -> two jobs buffered, one held at output, in_ready=0, out_result stable; release out_ready -> 3 correct results in order.
REQ-024 Stub multiplier never asserting mul_done, TIMEOUT=8 -> HOLD after 8 WAIT cycles, out_result=0, out_err=1; the next job (1,-1) completes normally with 1111.
REQ-025 Stub holds mul_done=1 across mul_start, drops it 1 cycle, then raises it with 0110 -> stale done ignored; out_result=0110.
REQ-026 rst pulsed mid-WAIT with 1 job buffered -> all outputs at reset values; the buffered job is discarded; a new job (-1,-1) yields 0001.
